key_schedule_ctrl: RTL and testbench

Sequences the combinational KeyExpansion datapath to build the full AES-128 round-key schedule, one round key per clock. It stores all 11 round keys (round 0 = cipher key, rounds 1..10 = expanded keys) in a local register file. Consumers read keys by round index, with a registered read port. It sits between the key-load interface and the round datapath; encrypt and decrypt both read the same stored schedule in different index order.

---
 rtl/key_schedule_ctrl_pkg.sv | 67 ++++++
 rtl/key_schedule_ctrl_if.sv | 31 +++
 rtl/key_schedule_ctrl_kexp.sv | 42 ++++
 rtl/key_schedule_ctrl.sv | 107 ++++++++++
 tb/tb_key_schedule_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_schedule_ctrl_pkg.sv
// key_schedule_ctrl_pkg
// Shared AES-128 key-schedule constants, FSM state encoding and the byte-level
// helpers (GF(2^8) multiply, S-box, SubWord, Rcon) used by the KeyExpansion
// datapath. The cipher datapath reuses these definitions.
package key_schedule_ctrl_pkg;

  localparam int unsigned KS_KEY_W      = 128;
  localparam int unsigned KS_NUM_ROUNDS = 10;
  localparam int unsigned KS_RND_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as affine(x^254); x^254 is the multiplicative inverse and
  // maps 0 to 0, which is what the affine step expects.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [KS_RND_W-1:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// key_schedule_ctrl_if
// Key-load and round-key read bus of the key scheduler.
//   i_Start/i_Key          : start pulse and cipher key
//   o_Busy/o_KeyValid/o_Done : expansion status
//   i_RdEn/i_RdRound       : read request by round index
//   o_RdKey/o_RdAck/o_RdErr : registered read response
// slave = scheduler side, master = key loader / round datapath side.
interface key_schedule_ctrl_if;
  import key_schedule_ctrl_pkg::*;

  logic                 i_Start;
  logic [KS_KEY_W-1:0]  i_Key;
  logic                 o_Busy;
  logic                 o_KeyValid;
  logic                 o_Done;
  logic                 i_RdEn;
  logic [KS_RND_W-1:0]  i_RdRound;
  logic [KS_KEY_W-1:0]  o_RdKey;
  logic                 o_RdAck;
  logic                 o_RdErr;

  modport slave (
    input  i_Start, i_Key, i_RdEn, i_RdRound,
    output o_Busy, o_KeyValid, o_Done, o_RdKey, o_RdAck, o_RdErr
  );

  modport master (
    output i_Start, i_Key, i_RdEn, i_RdRound,
    input  o_Busy, o_KeyValid, o_Done, o_RdKey, o_RdAck, o_RdErr
  );
endinterface

// File: rtl/key_schedule_ctrl_kexp.sv
// key_schedule_ctrl_kexp
// Combinational AES-128 KeyExpansion step.
//   i_Key     : current round key (word 0 in bits 127:96)
//   i_Round   : round number of the key being produced (encrypt) or of
//               i_Key (decrypt); selects Rcon
//   i_Encrypt : 1 = round r-1 -> r, 0 = round r -> r-1
//   o_Key     : resulting round key
module key_schedule_ctrl_kexp
  import key_schedule_ctrl_pkg::*;
(
  input  logic [KS_KEY_W-1:0] i_Key,
  input  logic [KS_RND_W-1:0] i_Round,
  input  logic                i_Encrypt,
  output logic [KS_KEY_W-1:0] o_Key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rc_word;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] p0, p1, p2, p3;

  assign w0      = i_Key[127:96];
  assign w1      = i_Key[95:64];
  assign w2      = i_Key[63:32];
  assign w3      = i_Key[31:0];
  assign rc_word = {rcon(i_Round), 24'h000000};

  // Forward step: RotWord/SubWord on word 3, then a running XOR chain.
  assign f0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ rc_word;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  // Inverse step: undo the XOR chain first, then recover word 0.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ rc_word;

  assign o_Key = i_Encrypt ? {f0, f1, f2, f3} : {p0, p1, p2, p3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl
// Builds the AES-128 round-key schedule one key per clock and stores all
// NUM_ROUNDS+1 round keys for indexed reads by the round datapath.
//   Clk : system clock, rising edge
//   Rst : asynchronous active-high reset
//   bus : key_schedule_ctrl_if.slave (start/key load, status, read port)
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = KS_NUM_ROUNDS,
  parameter int unsigned KEY_W      = KS_KEY_W
) (
  input  logic             Clk,
  input  logic             Rst,
  key_schedule_ctrl_if.slave bus
);

  localparam logic [KS_RND_W-1:0] LAST_RND = KS_RND_W'(NUM_ROUNDS);

  ks_state_e           state_q;
  logic [KS_RND_W-1:0] cnt_q;
  logic [KEY_W-1:0]    work_q;
  logic [KEY_W-1:0]    key_file_q [0:NUM_ROUNDS];
  logic                busy_q;
  logic                valid_q;
  logic                done_q;
  logic [KEY_W-1:0]    rd_key_q;
  logic                rd_ack_q;
  logic                rd_err_q;

  logic [KEY_W-1:0]    next_key_d;
  logic                start_acc_d;
  logic                rd_acc_d;

  key_schedule_ctrl_kexp u_kexp (
    .i_Key     (work_q),
    .i_Round   (cnt_q),
    .i_Encrypt (1'b1),
    .o_Key     (next_key_d)
  );

  assign start_acc_d = bus.i_Start && (state_q != ST_EXPAND);

  // A read coinciding with an accepted start is rejected: the schedule it
  // would read is being invalidated on that very edge.
  assign rd_acc_d = bus.i_RdEn && valid_q && !start_acc_d
                    && (bus.i_RdRound <= LAST_RND);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      rd_key_q <= '0;
      rd_ack_q <= 1'b0;
      rd_err_q <= 1'b0;
      for (int unsigned i = 0; i <= NUM_ROUNDS; i++) begin
        key_file_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE, ST_READY: begin
          if (start_acc_d) begin
            key_file_q[0] <= bus.i_Key;
            work_q        <= bus.i_Key;
            cnt_q         <= KS_RND_W'(1);
            busy_q        <= 1'b1;
            valid_q       <= 1'b0;
            state_q       <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          key_file_q[cnt_q] <= next_key_d;
          work_q            <= next_key_d;
          if (cnt_q == LAST_RND) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + KS_RND_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      rd_ack_q <= rd_acc_d;
      rd_err_q <= bus.i_RdEn && !rd_acc_d;
      if (rd_acc_d) begin
        rd_key_q <= key_file_q[bus.i_RdRound];
      end
    end
  end

  assign bus.o_Busy     = busy_q;
  assign bus.o_KeyValid = valid_q;
  assign bus.o_Done     = done_q;
  assign bus.o_RdKey    = rd_key_q;
  assign bus.o_RdAck    = rd_ack_q;
  assign bus.o_RdErr    = rd_err_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl
// Scoreboard bench: the stimulus process pushes the expected read response
// for every read request; a monitor pops and compares one cycle later.
// Reference schedule uses a table S-box and the FIPS-197 word recurrence.
module tb_key_schedule_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  key_schedule_ctrl_if ks_if ();

  key_schedule_ctrl #(.NUM_ROUNDS(10), .KEY_W(128)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (ks_if)
  );

  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] KEY_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] KEY_A10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B   = 128'h5468617473206d79204b756e67204675;
  localparam logic [127:0] KEY_B1  = 128'he232fcf191129188b159e4e6d679a293;
  localparam logic [127:0] KEY_B10 = 128'h28fddef86da4244accc0a4fe3b316f26;

  typedef struct {
    logic         ack;
    logic [127:0] key;
    int           rnd;
  } exp_t;

  exp_t exp_q [$];

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [127:0] sched [0:10];
  logic [127:0] pend  [0:10];
  logic [127:0] last_key = '0;
  logic         model_valid = 1'b0;
  logic         exp_done = 1'b0;
  int           exp_left = 0;

  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    int idx;
    idx = int'(b);
    return SBOX_T[2047 - 8*idx -: 8];
  endfunction

  task automatic build(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    int rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sb(temp[31:24]), sb(temp[23:16]), sb(temp[15:8]), sb(temp[7:0])}
               ^ {rc[7:0], 24'h000000};
        rc = rc * 2;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) pend[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Advance one clock; inputs return to idle and the status outputs are
  // checked against the model's view of the expansion progress.
  task automatic clk_step();
    @(negedge Clk);
    ks_if.i_Start = 1'b0;
    ks_if.i_RdEn  = 1'b0;
    exp_done = 1'b0;
    if (exp_left > 0) begin
      exp_left--;
      if (exp_left == 0) begin
        model_valid = 1'b1;
        exp_done    = 1'b1;
        for (int r = 0; r <= 10; r++) sched[r] = pend[r];
      end
    end
    if (!Rst) begin
      check_b("o_Busy", ks_if.o_Busy, exp_left > 0);
      check_b("o_KeyValid", ks_if.o_KeyValid, model_valid);
      check_b("o_Done", ks_if.o_Done, exp_done);
    end
  endtask

  task automatic start_key(input logic [127:0] key);
    ks_if.i_Start = 1'b1;
    ks_if.i_Key   = key;
    if (exp_left == 0) begin
      model_valid = 1'b0;
      exp_left    = 11;
      build(key);
    end
  endtask

  task automatic issue_read(input int r, input bit has_ref, input logic [127:0] ref_key);
    exp_t e;
    ks_if.i_RdEn    = 1'b1;
    ks_if.i_RdRound = r[3:0];
    e.rnd = r;
    if (model_valid && r <= 10) begin
      e.ack    = 1'b1;
      e.key    = has_ref ? ref_key : sched[r];
      last_key = e.key;
    end else begin
      e.ack = 1'b0;
      e.key = last_key;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    ks_if.i_Start = 1'b0;
    ks_if.i_RdEn  = 1'b0;
    #2 Rst = 1'b1;
    #1;
    check_b("rst o_Busy", ks_if.o_Busy, 1'b0);
    check_b("rst o_KeyValid", ks_if.o_KeyValid, 1'b0);
    check_b("rst o_Done", ks_if.o_Done, 1'b0);
    check_w("rst o_RdKey", ks_if.o_RdKey, '0);
    check_b("rst o_RdAck", ks_if.o_RdAck, 1'b0);
    check_b("rst o_RdErr", ks_if.o_RdErr, 1'b0);
    model_valid = 1'b0;
    exp_left    = 0;
    exp_done    = 1'b0;
    last_key    = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  // Monitor: a request seen at an edge must produce exactly one response.
  initial begin
    logic req;
    logic rst_s;
    exp_t e;
    forever begin
      @(posedge Clk);
      req   = ks_if.i_RdEn;
      rst_s = Rst;
      #1;
      if (rst_s || Rst) continue;
      if (req) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard: response with empty queue, ack=%b err=%b", ks_if.o_RdAck, ks_if.o_RdErr);
        end else begin
          e = exp_q.pop_front();
          check_b($sformatf("o_RdAck r=%0d", e.rnd), ks_if.o_RdAck, e.ack);
          check_b($sformatf("o_RdErr r=%0d", e.rnd), ks_if.o_RdErr, !e.ack);
          check_w($sformatf("o_RdKey r=%0d", e.rnd), ks_if.o_RdKey, e.key);
        end
      end else begin
        check_b("idle o_RdAck", ks_if.o_RdAck, 1'b0);
        check_b("idle o_RdErr", ks_if.o_RdErr, 1'b0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ks_if.i_Start   = 1'b0;
    ks_if.i_Key     = '0;
    ks_if.i_RdEn    = 1'b0;
    ks_if.i_RdRound = '0;
    do_reset();
    clk_step();

    // FIPS-197 key; a read and an ignored restart during expansion.
    start_key(KEY_A);
    clk_step();
    for (int c = 0; c < 10; c++) begin
      if (c == 2) issue_read(5, 1'b0, '0);
      if (c == 3) start_key({$urandom, $urandom, $urandom, $urandom});
      clk_step();
    end
    clk_step();
    issue_read(0, 1'b1, KEY_A);   clk_step();
    issue_read(1, 1'b1, KEY_A1);  clk_step();
    issue_read(10, 1'b1, KEY_A10); clk_step();
    issue_read(11, 1'b0, '0);     clk_step();
    issue_read(15, 1'b0, '0);     clk_step();

    // Decrypt order, back to back.
    for (int r = 10; r >= 0; r--) begin
      issue_read(r, 1'b0, '0);
      clk_step();
    end

    // Restart from READY with a read on the same edge.
    start_key(KEY_B);
    issue_read(3, 1'b0, '0);
    for (int c = 0; c < 12; c++) clk_step();
    issue_read(1, 1'b1, KEY_B1);  clk_step();
    issue_read(10, 1'b1, KEY_B10); clk_step();

    // Reset in the middle of an expansion.
    start_key({$urandom, $urandom, $urandom, $urandom});
    for (int c = 0; c < 5; c++) clk_step();
    do_reset();
    clk_step();
    issue_read(0, 1'b0, '0);
    clk_step();
    start_key(KEY_A);
    for (int c = 0; c < 11; c++) clk_step();
    issue_read(10, 1'b1, KEY_A10); clk_step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 5) start_key({$urandom, $urandom, $urandom, $urandom});
      if ($urandom_range(0, 99) < 60) begin
        if ($urandom_range(0, 3) == 0) issue_read(int'($urandom_range(11, 15)), 1'b0, '0);
        else                           issue_read(int'($urandom_range(0, 10)), 1'b0, '0);
      end
      clk_step();
    end

    repeat (3) clk_step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue drained: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
